// File: rtl/aes_result_sender_if.sv
// Result-in and byte-stream-out handshake bundle of aes_result_sender.
// The slave modport is the sender's view; master is the datapath/consumer side.
interface aes_result_sender_if #(
    parameter int STATE_BYTES = 16
);
    logic                       res_valid;
    logic                       res_ready;
    logic [8*STATE_BYTES-1:0]   res_cipher;
    logic [8*STATE_BYTES-1:0]   res_plain;
    logic [8*STATE_BYTES-1:0]   res_expect;
    logic                       res_eom;
    logic                       tx_valid;
    logic                       tx_ready;
    logic [7:0]                 tx_byte;
    logic                       tx_last;
    logic                       tx_eom;

    modport slave (
        input  res_valid, res_cipher, res_plain, res_expect, res_eom, tx_ready,
        output res_ready, tx_valid, tx_byte, tx_last, tx_eom
    );

    modport master (
        output res_valid, res_cipher, res_plain, res_expect, res_eom, tx_ready,
        input  res_ready, tx_valid, tx_byte, tx_last, tx_eom
    );
endinterface

// File: rtl/aes_result_sender.sv
// Buffers AES results, flags plaintext mismatches and serializes each result
// as a {cipher, plain, status} byte element onto a valid/ready stream.
module aes_result_sender #(
    parameter int FIFO_DEPTH  = 4,
    parameter int STATE_BYTES = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    aes_result_sender_if.slave     bus,
    output logic [COUNT_WIDTH-1:0] mismatch_count,
    output logic                   done
);
    localparam int SW        = 8 * STATE_BYTES;
    localparam int LAST_IDX  = 2 * STATE_BYTES;
    localparam int NUM_BYTES = LAST_IDX + 1;
    localparam int IW        = $clog2(NUM_BYTES);
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = $clog2(FIFO_DEPTH + 1);
    localparam int EW        = 2 * SW + 2;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [IW-1:0]          idx_reg, idx_next;
    logic                   tx_valid_reg, tx_valid_next;
    logic [7:0]             tx_byte_reg, tx_byte_next;
    logic                   tx_last_reg, tx_last_next;
    logic                   tx_eom_reg, tx_eom_next;
    logic                   done_reg, done_next;
    logic                   eom_seen_reg;
    logic                   ready_en_reg;
    logic [COUNT_WIDTH-1:0] mismatch_count_reg;

    logic [EW-1:0]          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]          count_reg;
    logic [EW-1:0]          hold_reg;

    logic                   fifo_full, fifo_empty, res_ready, push, pop, mism_in;
    logic [IW-1:0]          idx_inc;
    logic [7:0]             lane [NUM_BYTES];

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    // ready_en keeps res_ready low through the first edge after reset
    assign res_ready  = ready_en_reg && !fifo_full && !eom_seen_reg && !done_reg;
    assign push       = bus.res_valid && res_ready;
    assign mism_in    = (bus.res_plain != bus.res_expect);
    assign idx_inc    = idx_reg + IW'(1);

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {bus.res_cipher, bus.res_plain, mism_in, bus.res_eom};
    end

    always_ff @(posedge clock) begin
        if (pop)
            hold_reg <= fifo_mem[rd_ptr_reg];
    end

    // Byte lanes of the held entry in transmit order, status byte last
    generate
        for (genvar gi = 0; gi < STATE_BYTES; gi++) begin : g_lane
            assign lane[gi]               = hold_reg[EW-1-8*gi -: 8];
            assign lane[STATE_BYTES + gi] = hold_reg[SW+1-8*gi -: 8];
        end
    endgenerate
    assign lane[LAST_IDX] = {7'b0, hold_reg[1]};

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        tx_valid_next = tx_valid_reg;
        tx_byte_next  = tx_byte_reg;
        tx_last_next  = tx_last_reg;
        tx_eom_next   = tx_eom_reg;
        done_next     = done_reg;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_valid_next = 1'b0;
                tx_last_next  = 1'b0;
                tx_eom_next   = 1'b0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                idx_next      = '0;
                tx_valid_next = 1'b1;
                tx_byte_next  = lane[0];
                tx_last_next  = 1'b0;
                tx_eom_next   = 1'b0;
                state_next    = SEND;
            end
            SEND: begin
                if (tx_valid_reg && bus.tx_ready) begin
                    if (idx_reg == IW'(LAST_IDX)) begin
                        tx_valid_next = 1'b0;
                        tx_last_next  = 1'b0;
                        tx_eom_next   = 1'b0;
                        if (hold_reg[0]) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end else if (!fifo_empty) begin
                            pop        = 1'b1;
                            state_next = LOAD;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_next     = idx_inc;
                        tx_byte_next = lane[idx_inc];
                        tx_last_next = (idx_inc == IW'(LAST_IDX));
                        tx_eom_next  = (idx_inc == IW'(LAST_IDX)) && hold_reg[0];
                    end
                end
            end
            DONE: begin
                tx_valid_next = 1'b0;
                done_next     = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= IDLE;
            idx_reg            <= '0;
            tx_valid_reg       <= 1'b0;
            tx_byte_reg        <= '0;
            tx_last_reg        <= 1'b0;
            tx_eom_reg         <= 1'b0;
            done_reg           <= 1'b0;
            eom_seen_reg       <= 1'b0;
            ready_en_reg       <= 1'b0;
            mismatch_count_reg <= '0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            tx_valid_reg <= tx_valid_next;
            tx_byte_reg  <= tx_byte_next;
            tx_last_reg  <= tx_last_next;
            tx_eom_reg   <= tx_eom_next;
            done_reg     <= done_next;
            ready_en_reg <= 1'b1;
            if (push && bus.res_eom)
                eom_seen_reg <= 1'b1;
            if (push && mism_in && (mismatch_count_reg != '1))
                mismatch_count_reg <= mismatch_count_reg + COUNT_WIDTH'(1);
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (push && !pop)
                count_reg <= count_reg + CW'(1);
            else if (pop && !push)
                count_reg <= count_reg - CW'(1);
        end
    end

    assign bus.res_ready  = res_ready;
    assign bus.tx_valid   = tx_valid_reg;
    assign bus.tx_byte    = tx_byte_reg;
    assign bus.tx_last    = tx_last_reg;
    assign bus.tx_eom     = tx_eom_reg;
    assign mismatch_count = mismatch_count_reg;
    assign done           = done_reg;
endmodule

// File: tb/tb_aes_result_sender.sv
// Directed bench for aes_result_sender: latency, mismatch, backpressure,
// FIFO full, end-of-message gating and mid-frame reset.
module tb_aes_result_sender;
    logic        clock;
    logic        reset;
    logic [15:0] mismatch_count;
    logic        done;

    aes_result_sender_if #(.STATE_BYTES(16)) bus ();

    aes_result_sender #(.FIFO_DEPTH(4), .STATE_BYTES(16), .COUNT_WIDTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .mismatch_count (mismatch_count),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    int pass_count  = 0;
    int check_count = 0;
    int fail_count  = 0;

    logic [7:0] got_byte [256];
    logic       got_last [256];
    logic       got_eom  [256];
    int         got_n, stall_err, rr_high;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [127:0] c, input logic [127:0] p,
                                            input logic m, input int i);
        if (i < 16) return c[127-8*i -: 8];
        if (i < 32) return p[127-8*(i-16) -: 8];
        return {7'b0, m};
    endfunction

    task automatic push(input logic [127:0] c, input logic [127:0] p,
                        input logic [127:0] x, input logic e);
        int w;
        bus.res_valid  = 1'b1;
        bus.res_cipher = c;
        bus.res_plain  = p;
        bus.res_expect = x;
        bus.res_eom    = e;
        w = 0;
        while (!bus.res_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        check("push_accept", {63'b0, bus.res_ready}, 64'd1);
        @(negedge clock);
        bus.res_valid = 1'b0;
    endtask

    // mode 0: tx_ready held high; mode 1: tx_ready pattern 1,0,0,1
    task automatic collect(input int n, input int mode, input int budget);
        logic       prev_stall;
        logic [7:0] sb;
        logic       sl, se;
        got_n = 0; stall_err = 0; rr_high = 0; prev_stall = 1'b0;
        sb = '0; sl = 1'b0; se = 1'b0;
        for (int c = 0; c < budget && got_n < n; c++) begin
            bus.tx_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (prev_stall && (bus.tx_byte !== sb || bus.tx_last !== sl || bus.tx_eom !== se))
                stall_err++;
            prev_stall = bus.tx_valid && !bus.tx_ready;
            sb = bus.tx_byte; sl = bus.tx_last; se = bus.tx_eom;
            if (bus.res_ready) rr_high++;
            if (bus.tx_valid && bus.tx_ready) begin
                got_byte[got_n] = bus.tx_byte;
                got_last[got_n] = bus.tx_last;
                got_eom[got_n]  = bus.tx_eom;
                got_n++;
            end
            @(negedge clock);
        end
        check("collect_count", 64'(got_n), 64'(n));
    endtask

    task automatic check_element(input string tag, input int base, input logic [127:0] c,
                                 input logic [127:0] p, input logic m, input logic e);
        int berr, lerr, eerr;
        berr = 0; lerr = 0; eerr = 0;
        for (int i = 0; i < 33; i++) begin
            if (got_byte[base+i] !== exp_byte(c, p, m, i)) berr++;
            if (got_last[base+i] !== (i == 32)) lerr++;
            if (got_eom[base+i] !== ((i == 32) && e)) eerr++;
        end
        $display("[%0t] element %s: first byte %02h status %02h", $time, tag,
                 got_byte[base], got_byte[base+32]);
        check({tag, "_bytes"}, 64'(berr), 64'd0);
        check({tag, "_last"}, 64'(lerr), 64'd0);
        check({tag, "_eom"}, 64'(eerr), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.res_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset          = 1'b1;
        bus.res_valid  = 1'b0;
        bus.res_cipher = '0;
        bus.res_plain  = '0;
        bus.res_expect = '0;
        bus.res_eom    = 1'b0;
        bus.tx_ready   = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_res_ready", {63'b0, bus.res_ready}, 64'd0);
        check("rst_tx_valid", {63'b0, bus.tx_valid}, 64'd0);
        check("rst_tx_byte", {56'b0, bus.tx_byte}, 64'd0);
        check("rst_tx_last", {63'b0, bus.tx_last}, 64'd0);
        check("rst_tx_eom", {63'b0, bus.tx_eom}, 64'd0);
        check("rst_count", {48'b0, mismatch_count}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        reset = 1'b0;
        check("ready_at_deassert", {63'b0, bus.res_ready}, 64'd0);
        @(negedge clock);
        check("ready_after_deassert", {63'b0, bus.res_ready}, 64'd1);

        // 1: single matching vector, latency and done
        bus.tx_ready = 1'b1;
        push(C1, P1, P1, 1'b1);
        check("s1_valid_n1", {63'b0, bus.tx_valid}, 64'd0);
        @(negedge clock);
        check("s1_valid_n2", {63'b0, bus.tx_valid}, 64'd0);
        @(negedge clock);
        check("s1_first_valid", {63'b0, bus.tx_valid}, 64'd1);
        collect(33, 0, 100);
        check("s1_byte0", {56'b0, got_byte[0]}, 64'h69);
        check("s1_byte15", {56'b0, got_byte[15]}, 64'h5a);
        check("s1_byte31", {56'b0, got_byte[31]}, 64'hff);
        check("s1_status", {56'b0, got_byte[32]}, 64'h00);
        check_element("s1", 0, C1, P1, 1'b0, 1'b1);
        check("s1_done", {63'b0, done}, 64'd1);
        check("s1_count", {48'b0, mismatch_count}, 64'd0);
        check("s1_ready_low", {63'b0, bus.res_ready}, 64'd0);

        // 2: bit-0 mismatch, then a matching vector
        do_reset();
        push(C1, P1, P1 ^ 128'd1, 1'b0);
        collect(33, 0, 100);
        check("s2_status_mism", {56'b0, got_byte[32]}, 64'h01);
        check_element("s2a", 0, C1, P1, 1'b1, 1'b0);
        check("s2_count1", {48'b0, mismatch_count}, 64'd1);
        push(C2, P2, P2, 1'b1);
        collect(33, 0, 100);
        check("s2_status_match", {56'b0, got_byte[32]}, 64'h00);
        check_element("s2b", 0, C2, P2, 1'b0, 1'b1);
        check("s2_count_hold", {48'b0, mismatch_count}, 64'd1);

        // 3: backpressure pattern 1,0,0,1
        do_reset();
        bus.tx_ready = 1'b0;
        push(C1, P1, P1, 1'b1);
        collect(33, 1, 300);
        check("s3_stall_stable", 64'(stall_err), 64'd0);
        check_element("s3", 0, C1, P1, 1'b0, 1'b1);
        check("s3_done", {63'b0, done}, 64'd1);

        // 4: FIFO full with tx stalled, then drain in order
        do_reset();
        bus.tx_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            push({8'ha0 + 8'(k), C1[119:0]}, P1, P1, 1'b0);
        check("s4_full_ready", {63'b0, bus.res_ready}, 64'd0);
        bus.res_valid  = 1'b1;
        bus.res_cipher = C2;
        repeat (3) @(negedge clock);
        check("s4_still_full", {63'b0, bus.res_ready}, 64'd0);
        bus.res_valid = 1'b0;
        collect(165, 0, 400);
        for (int k = 0; k < 5; k++)
            check($sformatf("s4_id%0d", k), {56'b0, got_byte[33*k]}, 64'(8'ha0 + k));
        check_element("s4e4", 132, {8'ha4, C1[119:0]}, P1, 1'b0, 1'b0);
        check("s4_not_done", {63'b0, done}, 64'd0);

        // 5: end-of-message gating
        do_reset();
        bus.tx_ready = 1'b1;
        push(C2, P2, P2, 1'b0);
        push(C1, P1, P1, 1'b1);
        bus.res_valid  = 1'b1;
        bus.res_cipher = C2;
        bus.res_plain  = P2;
        bus.res_expect = ~P2;
        bus.res_eom    = 1'b0;
        collect(66, 0, 200);
        check("s5_c_blocked", 64'(rr_high), 64'd0);
        check_element("s5a", 0, C2, P2, 1'b0, 1'b0);
        check_element("s5b", 33, C1, P1, 1'b0, 1'b1);
        repeat (5) @(negedge clock);
        check("s5_done_hold", {63'b0, done}, 64'd1);
        check("s5_idle", {63'b0, bus.tx_valid}, 64'd0);
        check("s5_count", {48'b0, mismatch_count}, 64'd0);
        bus.res_valid = 1'b0;

        // 6: reset at byte index 10 with two entries queued
        do_reset();
        bus.tx_ready = 1'b1;
        push(C1, P1, ~P1, 1'b0);
        push(C2, P2, ~P2, 1'b0);
        push(C2, P1, P1, 1'b0);
        collect(10, 0, 100);
        check("s6_pre_count", {48'b0, mismatch_count}, 64'd2);
        reset = 1'b1;
        @(negedge clock);
        check("s6_tx_valid", {63'b0, bus.tx_valid}, 64'd0);
        check("s6_tx_byte", {56'b0, bus.tx_byte}, 64'd0);
        check("s6_tx_last", {63'b0, bus.tx_last}, 64'd0);
        check("s6_count_rst", {48'b0, mismatch_count}, 64'd0);
        check("s6_ready_rst", {63'b0, bus.res_ready}, 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("s6_fifo_flushed", {63'b0, bus.tx_valid}, 64'd0);
        push(C2, P2, P2 ^ 128'h80, 1'b1);
        collect(33, 0, 100);
        check_element("s6", 0, C2, P2, 1'b1, 1'b1);
        check("s6_count_restart", {48'b0, mismatch_count}, 64'd1);
        check("s6_done", {63'b0, done}, 64'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
